reg_file: RTL and testbench

- Register file feeding the ALU operand inputs `a` and `b`.
- It is the stage directly upstream of the ALU, and also receives the ALU result on write-back.
- Provides two combinational read ports, one synchronous write port, r0 hardwired to zero, same-cycle write-through bypass, and a registered zero flag captured from the ALU.
- Sits between the decode/control logic and the ALU in the 8-bit RISC datapath.

---
 rtl/reg_file.sv | 71 +++++++
 tb/tb_reg_file.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// ALU operand register file: two combinational read ports with write-through
// bypass, one synchronous write port, r0 hardwired to zero, registered zero flag.
module reg_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_we,
    input  logic              alu_zero,
    output logic              zero_flag
);

    localparam int NREG = 1 << ADDR_W;

    // r0 has no storage; only r1..r(N-1) exist as flops.
    logic [DATA_W-1:0] regs [1:NREG-1];
    logic              wr_valid;

    assign wr_valid = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_valid && (wr_addr == i[ADDR_W-1:0])) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_flag <= 1'b0;
        end else if (flag_we) begin
            zero_flag <= alu_zero;
        end
    end

    // Bypass depends on wr_en only, so it still forwards while reset is held.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        for (int i = 1; i < NREG; i++) begin
            if (addr == i[ADDR_W-1:0]) begin
                val = regs[i];
            end
        end
        if (wr_valid && (wr_addr == addr)) begin
            val = wr_data;
        end
        return val;
    endfunction

    always_comb begin
        rd_data1 = read_port(rd_addr1);
        rd_data2 = read_port(rd_addr2);
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read-back, r0, bypass, zero flag, full sweep.
module tb_reg_file;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              flag_we;
    logic              alu_zero;
    logic              zero_flag;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .flag_we  (flag_we),
        .alu_zero (alu_zero),
        .zero_flag(zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp1, exp2;
        rst_n    = 1'b0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        flag_we  = 1'b0;
        alu_zero = 1'b0;
        #2;
        rd_addr1 = 3'd1;
        rd_addr2 = 3'd7;
        #1;
        check("init_rd1", rd_data1, 8'h00);
        check("init_rd2", rd_data2, 8'h00);
        check("init_zf", {7'b0, zero_flag}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Write r3 and set the flag, then reset mid-cycle
        tick();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A;
        flag_we = 1'b1; alu_zero = 1'b1;
        tick();
        wr_en = 1'b0; flag_we = 1'b0; alu_zero = 1'b0;
        rd_addr1 = 3'd3; rd_addr2 = 3'd0;
        #1;
        check("r3_before_rst", rd_data1, 8'h5A);
        check("zf_before_rst", {7'b0, zero_flag}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("r3_in_rst", rd_data1, 8'h00);
        check("r0_in_rst", rd_data2, 8'h00);
        check("zf_in_rst", {7'b0, zero_flag}, 8'h00);
        // Bypass stays active during reset, but the write itself is dropped
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h99; rd_addr2 = 3'd2;
        #1;
        check("bypass_in_rst", rd_data2, 8'h99);
        tick();
        wr_en = 1'b0;
        #1;
        check("write_in_rst_dropped", rd_data2, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Write/read-back
        tick();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h3C;
        tick();
        wr_addr = 3'd2; wr_data = 8'hC3;
        tick();
        wr_en = 1'b0; rd_addr1 = 3'd1; rd_addr2 = 3'd2;
        #1;
        check("r1_readback", rd_data1, 8'h3C);
        check("r2_readback", rd_data2, 8'hC3);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h3C + 8'hC3;
        tick();
        wr_en = 1'b0; rd_addr1 = 3'd4;
        #1;
        check("r4_readback", rd_data1, 8'hFF);
        check("r2_unchanged", rd_data2, 8'hC3);

        // r0 hardwired, no bypass to r0
        rd_addr1 = 3'd0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hAA;
        #1;
        check("r0_before_edge", rd_data1, 8'h00);
        tick();
        wr_en = 1'b0;
        #1;
        check("r0_after_edge", rd_data1, 8'h00);

        // Bypass on both ports
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h11;
        tick();
        wr_en = 1'b0; rd_addr1 = 3'd5; rd_addr2 = 3'd5;
        #1;
        check("r5_stored", rd_data1, 8'h11);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h77;
        #1;
        check("bypass_rd1", rd_data1, 8'h77);
        check("bypass_rd2", rd_data2, 8'h77);
        tick();
        wr_en = 1'b0;
        #1;
        check("r5_after_rd1", rd_data1, 8'h77);
        check("r5_after_rd2", rd_data2, 8'h77);

        // Zero flag capture / hold / clear
        flag_we = 1'b1; alu_zero = 1'b1;
        tick();
        check("zf_set", {7'b0, zero_flag}, 8'h01);
        flag_we = 1'b0; alu_zero = 1'b0;
        tick();
        check("zf_hold", {7'b0, zero_flag}, 8'h01);
        flag_we = 1'b1;
        tick();
        check("zf_clear", {7'b0, zero_flag}, 8'h00);
        flag_we = 1'b0;

        // Full sweep
        for (int i = 1; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = i[2:0]; wr_data = 8'(i * 16);
            tick();
        end
        wr_en = 1'b0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                rd_addr1 = a[2:0];
                rd_addr2 = b[2:0];
                #1;
                exp1 = 8'(a * 16);
                exp2 = 8'(b * 16);
                check($sformatf("sweep_rd1_%0d_%0d", a, b), rd_data1, exp1);
                check($sformatf("sweep_rd2_%0d_%0d", a, b), rd_data2, exp2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
